shapool_ctrl: RTL

//   Job sequencer between external_io and the shapool hash core. On start it seeds the nonce from device_config.
//   It then loads the core, waits for each round and steps the nonce by NONCE_STRIDE.

---
 rtl/shapool_ctrl_pkg.sv | 21 ++
 rtl/shapool_ctrl_if.sv | 22 ++
 rtl/shapool_ctrl_nonce_counter.sv | 46 ++++
 rtl/shapool_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/shapool_ctrl_pkg.sv
// shapool_ctrl_pkg
//   Shared definitions for the shapool job sequencer:
//   - 3-bit state encodings
//   - default nonce and device_config widths, also used by external_io
//   - start_allowed(): true in the states that accept a new job
package shapool_ctrl_pkg;

   localparam int NONCE_WIDTH_DEF         = 32;
   localparam int DEVICE_CONFIG_WIDTH_DEF = 8;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LOAD      = 3'd1;
   localparam logic [2:0] ST_HASH      = 3'd2;
   localparam logic [2:0] ST_SUCCESS   = 3'd3;
   localparam logic [2:0] ST_EXHAUSTED = 3'd4;

   function automatic logic start_allowed(input logic [2:0] st);
      return (st == ST_IDLE) || (st == ST_SUCCESS) || (st == ST_EXHAUSTED);
   endfunction

endpackage

// File: rtl/shapool_ctrl_if.sv
// shapool_ctrl_if
//   Handshake between the job sequencer and the shapool hash core.
//   core_load  : 1-cycle pulse, core latches core_nonce and starts a round
//   core_nonce : nonce under test
//   core_done  : 1-cycle pulse, round finished
//   core_match : hash met target, qualified by core_done
//   master = sequencer side, slave = hash core side.
interface shapool_ctrl_if
   import shapool_ctrl_pkg::*;
#(
   parameter int NONCE_WIDTH = NONCE_WIDTH_DEF
) ();

   logic                   core_load;
   logic [NONCE_WIDTH-1:0] core_nonce;
   logic                   core_done;
   logic                   core_match;

   modport master (output core_load, output core_nonce, input core_done, input core_match);
   modport slave  (input core_load, input core_nonce, output core_done, output core_match);

endinterface

// File: rtl/shapool_ctrl_nonce_counter.sv
// shapool_ctrl_nonce_counter
//   Nonce register for the job sequencer. Loads the zero-extended seed, or
//   steps by NONCE_STRIDE. The carry of the next step is always visible, so
//   the FSM can stop before the nonce would wrap.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   i_seed_load   load nonce from i_seed (has priority over i_step)
//   i_seed        device_config seed
//   i_step        nonce <= nonce + NONCE_STRIDE
//   o_nonce       current nonce
//   o_carry       carry-out of nonce + NONCE_STRIDE
module shapool_ctrl_nonce_counter
   import shapool_ctrl_pkg::*;
#(
   parameter int NONCE_WIDTH         = NONCE_WIDTH_DEF,
   parameter int DEVICE_CONFIG_WIDTH = DEVICE_CONFIG_WIDTH_DEF,
   parameter int NONCE_STRIDE        = 1
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           i_seed_load,
   input  logic [DEVICE_CONFIG_WIDTH-1:0] i_seed,
   input  logic                           i_step,
   output logic [NONCE_WIDTH-1:0]         o_nonce,
   output logic                           o_carry
);

   logic [NONCE_WIDTH-1:0] r_nonce;
   logic [NONCE_WIDTH:0]   w_sum;

   // One extra bit makes the wrap visible as a carry.
   assign w_sum   = {1'b0, r_nonce} + (NONCE_WIDTH+1)'(NONCE_STRIDE);
   assign o_carry = w_sum[NONCE_WIDTH];
   assign o_nonce = r_nonce;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_nonce <= '0;
      end else if (i_seed_load) begin
         r_nonce <= NONCE_WIDTH'(i_seed);
      end else if (i_step) begin
         r_nonce <= w_sum[NONCE_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/shapool_ctrl.sv
// shapool_ctrl
//   Job sequencer between external_io and the shapool hash core. A start
//   seeds the nonce from device_config. Each round loads the core, waits
//   for core_done and steps the nonce. The job ends on a match (result
//   latched, success raised) or when the next step would wrap (exhausted).
// Optional feature: SHAPOOL_CTRL_WATCHDOG_EN adds a HASH watchdog that
//   aborts to IDLE with timeout=1 after WATCHDOG_CYCLES cycles without core_done.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   start, stop      1-cycle job start / abort pulses (stop has priority)
//   device_config    nonce seed, sampled on an accepted start
//   core_if          master side of the hash core handshake
//   busy             high in LOAD/HASH
//   shapool_result   winning nonce, valid while shapool_success
//   shapool_success  match found, held until start/stop/reset
//   exhausted        nonce space used up, held until start/stop/reset
//   timeout          watchdog abort flag (constant 0 without the watchdog)
//
// state        | meaning
// -------------+------------------------------------------------
// ST_IDLE      | no job; waits for start
// ST_LOAD      | core_load pulse with the current nonce
// ST_HASH      | waits for core_done from the core
// ST_SUCCESS   | match found; result and success held
// ST_EXHAUSTED | nonce space ran out; exhausted held
module shapool_ctrl
   import shapool_ctrl_pkg::*;
#(
   parameter int NONCE_WIDTH         = NONCE_WIDTH_DEF,
   parameter int DEVICE_CONFIG_WIDTH = DEVICE_CONFIG_WIDTH_DEF,
   parameter int NONCE_STRIDE        = 1
`ifdef SHAPOOL_CTRL_WATCHDOG_EN
   ,
   parameter int WATCHDOG_CYCLES     = 1024
`endif
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic                           stop,
   input  logic [DEVICE_CONFIG_WIDTH-1:0] device_config,
   shapool_ctrl_if.master                 core_if,
   output logic                           busy,
   output logic [NONCE_WIDTH-1:0]         shapool_result,
   output logic                           shapool_success,
   output logic                           exhausted,
   output logic                           timeout
);

   logic [2:0]             r_state;
   logic [NONCE_WIDTH-1:0] r_result;
   logic                   r_success;
   logic                   r_exhausted;
   logic [NONCE_WIDTH-1:0] w_nonce;
   logic                   w_carry;
   logic                   w_start_ok;
   logic                   w_round_done;
   logic                   w_step;

   assign w_start_ok   = start && !stop && start_allowed(r_state);
   assign w_round_done = (r_state == ST_HASH) && core_if.core_done && !stop;
   assign w_step       = w_round_done && !core_if.core_match && !w_carry;

   shapool_ctrl_nonce_counter #(
      .NONCE_WIDTH         (NONCE_WIDTH),
      .DEVICE_CONFIG_WIDTH (DEVICE_CONFIG_WIDTH),
      .NONCE_STRIDE        (NONCE_STRIDE)
   ) u_nonce (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_seed_load (w_start_ok),
      .i_seed      (device_config),
      .i_step      (w_step),
      .o_nonce     (w_nonce),
      .o_carry     (w_carry)
   );

`ifdef SHAPOOL_CTRL_WATCHDOG_EN
   localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_timeout;
   logic            w_wd_expire;

   // Down-counter loaded in LOAD; terminal count on the last allowed HASH cycle.
   assign w_wd_expire = (r_state == ST_HASH) && !core_if.core_done && (r_wd_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wd_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == ST_LOAD) begin
            r_wd_cnt <= WD_W'(WATCHDOG_CYCLES - 1);
         end else if ((r_state == ST_HASH) && (r_wd_cnt != '0)) begin
            r_wd_cnt <= r_wd_cnt - 1'b1;
         end
         if (stop || w_start_ok) begin
            r_timeout <= 1'b0;
         end else if (w_wd_expire) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_result    <= '0;
         r_success   <= 1'b0;
         r_exhausted <= 1'b0;
      end else if (stop) begin
         r_state     <= ST_IDLE;
         r_result    <= '0;
         r_success   <= 1'b0;
         r_exhausted <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_SUCCESS, ST_EXHAUSTED: begin
               if (start) begin
                  r_state     <= ST_LOAD;
                  r_result    <= '0;
                  r_success   <= 1'b0;
                  r_exhausted <= 1'b0;
               end
            end
            ST_LOAD: r_state <= ST_HASH;
            ST_HASH: begin
               if (core_if.core_done) begin
                  if (core_if.core_match) begin
                     r_result  <= w_nonce;
                     r_success <= 1'b1;
                     r_state   <= ST_SUCCESS;
                  end else if (w_carry) begin
                     r_exhausted <= 1'b1;
                     r_state     <= ST_EXHAUSTED;
                  end else begin
                     r_state <= ST_LOAD;
                  end
               end
`ifdef SHAPOOL_CTRL_WATCHDOG_EN
               else if (w_wd_expire) begin
                  r_state <= ST_IDLE;
               end
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy               = (r_state == ST_LOAD) || (r_state == ST_HASH);
   assign core_if.core_load  = (r_state == ST_LOAD);
   assign core_if.core_nonce = w_nonce;
   assign shapool_result     = r_result;
   assign shapool_success    = r_success;
   assign exhausted          = r_exhausted;

endmodule
